adam_kbd_fifo: RTL and testbench
================================

Name: adam_kbd_fifo

Overview:
- Converts MiSTer-style `ps2_key` events into ADAM keyboard character codes.
- Tracks modifier state and generates typematic auto-repeat.
- Buffers the resulting codes in a show-ahead FIFO.
- Sits directly upstream of the console's ADAM keyboard/AdamNet logic, replacing raw scancode handling with a handshaked byte stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_DLY, 24'd5_370_000, clk_i cycles a key must be held before the first repeat (~0.5 s at 10.7 MHz).
- REPEAT_RATE, 24'd1_070_000, clk_i cycles between subsequent repeats.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- ps2_key_i  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event.
- rd_i  in  1  pop strobe; honoured only when valid_o=1.
- data_o  out  8  ADAM code at FIFO head.
- valid_o  out  1  FIFO not empty.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky flag: a code was dropped because the FIFO was full.

Behaviour:
- Clock and reset:
  - One clock: clk_i. Reset is synchronous and active-low on reset_n_i.
  - While reset_n_i=0: FIFO empty, valid_o=0, count_o=0, overflow_o=0, data_o=0, modifiers cleared, repeat FSM in IDLE.
  - On the first cycle out of reset, ps2_key_i[10] is captured with no event generated.
- Event detect:
  - An event occurs when ps2_key_i[10] differs from the registered previous value.
  - Stage 1 (edge k): register the scancode, ext and pressed bits.
  - Stage 2 (edge k+1): decode to a code, or mark unmapped.
  - Stage 3 (edge k+2): push. valid_o rises after edge k+2. Latency is 2 cycles, fully pipelined; events on consecutive cycles are all processed.
- Modifiers (never pushed):
  - Shift is held while 0x12 or 0x59 is down.
  - Ctrl is held while 0x14 is down, extended or not.
  - Caps lock: 0x58 toggles caps on make; break is ignored.
- Mapping (non-extended):
  - Letters: a..z give 0x61..0x7A. They become uppercase (0x41..0x5A) when shift XOR caps. Ctrl overrides case and gives letter & 0x1F.
  - Digits row 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 give '0'..'9' (0x30..0x39). With shift they give )!@#$%^&*( respectively.
  - 0x29 gives 0x20; 0x5A gives 0x0D; 0x66 gives 0x08; 0x76 gives 0x1B; 0x0D gives 0x09.
- Mapping (extended):
  - E075 gives 0xA0, E074 gives 0xA1, E072 gives 0xA2, E06B gives 0xA3.
- All other make codes, and every break code, push nothing.
- Repeat FSM:
  - States: IDLE, DELAY, REPEAT. A 24-bit counter is cleared on every state entry.
  - A mapped make latches the key identity (scancode and ext) and its decoded code, then enters DELAY. This applies from any state, so a new key restarts the sequence.
  - In DELAY, when counter reaches REPEAT_DLY-1, push the latched code and go to REPEAT.
  - In REPEAT, every REPEAT_RATE cycles, push the latched code.
  - A break matching the latched key returns to IDLE. Breaks of other keys and modifier changes do not affect the FSM; the latched code is not re-decoded.
- Push arbitration:
  - If a decoded push and a repeat push occur in the same cycle, the decoded push wins. The repeat push is discarded and its counter still restarts.
- FIFO:
  - Show-ahead: data_o is the head entry whenever valid_o=1.
  - Pop when rd_i & valid_o. rd_i while empty is ignored.
  - Push when not full.
  - Push while full with no pop: drop the code and set overflow_o.
  - Push and pop in the same cycle while full: both occur and count is unchanged.
  - Push and pop in the same cycle while empty: the push lands, and the pop is ignored because valid_o=0.
  - Pointers wrap modulo DEPTH.
  - overflow_o is cleared only by reset.
- Reset mid-operation discards the pipeline, FIFO contents, modifiers and repeat state.

Test Plan:
- Reset, then make 0x1C (toggle flip) -> valid_o=1 exactly 2 cycles later, data_o=0x61, count_o=1; rd_i pulse -> valid_o=0, count_o=0.
- Make 0x12, make 0x1C, break 0x1C, break 0x12, make 0x1C -> FIFO holds 0x41 then 0x61; no entries from breaks or the shift key.
- Make 0x58, make 0x14, make 0x32 -> single entry 0x02 (ctrl overrides caps); extended 0x75 make -> 0xA0.
- REPEAT_DLY=10, REPEAT_RATE=4, hold 0x29 for 30 cycles, then break -> initial 0x20, then repeats at +10, +14, +18, +22, +26 cycles; nothing after the break; make 0x1C during DELAY restarts the sequence with 0x61.
- DEPTH=4: push 5 codes without reading -> count_o=4, overflow_o=1, data_o=first code; pop while pushing at full -> count_o stays 4, order preserved across pointer wrap.
- Assert reset_n_i low for 1 cycle with 3 entries queued and the repeat FSM in REPEAT -> count_o=0, valid_o=0, overflow_o=0, no further repeats.

Source files
------------

// File: rtl/adam_kbd_fifo.sv
// adam_kbd_fifo: ps2_key events to ADAM codes with modifiers, typematic repeat and a show-ahead FIFO
module adam_kbd_fifo #(
    parameter int          DEPTH       = 8,
    parameter logic [23:0] REPEAT_DLY  = 24'd5_370_000,
    parameter logic [23:0] REPEAT_RATE = 24'd1_070_000
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [10:0]              ps2_key_i,
    input  logic                     rd_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    function automatic logic [7:0] f_letter(input logic [7:0] s);
        case (s)
            8'h1C: f_letter = 8'h61;  8'h32: f_letter = 8'h62;  8'h21: f_letter = 8'h63;
            8'h23: f_letter = 8'h64;  8'h24: f_letter = 8'h65;  8'h2B: f_letter = 8'h66;
            8'h34: f_letter = 8'h67;  8'h33: f_letter = 8'h68;  8'h43: f_letter = 8'h69;
            8'h3B: f_letter = 8'h6A;  8'h42: f_letter = 8'h6B;  8'h4B: f_letter = 8'h6C;
            8'h3A: f_letter = 8'h6D;  8'h31: f_letter = 8'h6E;  8'h44: f_letter = 8'h6F;
            8'h4D: f_letter = 8'h70;  8'h15: f_letter = 8'h71;  8'h2D: f_letter = 8'h72;
            8'h1B: f_letter = 8'h73;  8'h2C: f_letter = 8'h74;  8'h3C: f_letter = 8'h75;
            8'h2A: f_letter = 8'h76;  8'h1D: f_letter = 8'h77;  8'h22: f_letter = 8'h78;
            8'h35: f_letter = 8'h79;  8'h1A: f_letter = 8'h7A;
            default: f_letter = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] f_digit(input logic [7:0] s, input logic sh);
        case (s)
            8'h45: f_digit = sh ? 8'h29 : 8'h30;
            8'h16: f_digit = sh ? 8'h21 : 8'h31;
            8'h1E: f_digit = sh ? 8'h40 : 8'h32;
            8'h26: f_digit = sh ? 8'h23 : 8'h33;
            8'h25: f_digit = sh ? 8'h24 : 8'h34;
            8'h2E: f_digit = sh ? 8'h25 : 8'h35;
            8'h36: f_digit = sh ? 8'h5E : 8'h36;
            8'h3D: f_digit = sh ? 8'h26 : 8'h37;
            8'h3E: f_digit = sh ? 8'h2A : 8'h38;
            8'h46: f_digit = sh ? 8'h28 : 8'h39;
            default: f_digit = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] f_misc(input logic [7:0] s);
        case (s)
            8'h29: f_misc = 8'h20;
            8'h5A: f_misc = 8'h0D;
            8'h66: f_misc = 8'h08;
            8'h76: f_misc = 8'h1B;
            8'h0D: f_misc = 8'h09;
            default: f_misc = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] f_ext(input logic [7:0] s);
        case (s)
            8'h75: f_ext = 8'hA0;
            8'h74: f_ext = 8'hA1;
            8'h72: f_ext = 8'hA2;
            8'h6B: f_ext = 8'hA3;
            default: f_ext = 8'h00;
        endcase
    endfunction

    logic        r_armed, r_tog;
    logic        r_s1_v, r_s1_ext, r_s1_mk;
    logic [7:0]  r_s1_scan;
    logic        r_lsh, r_rsh, r_ctrl, r_caps;
    logic        r_s2_push, r_s2_brk, r_s2_ext;
    logic [7:0]  r_s2_scan, r_s2_code;
    state_t      r_state;
    logic [23:0] r_cnt;
    logic [8:0]  r_rkey;
    logic [7:0]  r_rcode;
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_fcnt;
    logic        r_ovf;

    logic        w_evt, w_s1_std, w_shift;
    logic [7:0]  w_let, w_dig, w_code;
    logic        w_dly_done, w_rate_done, w_brk_hit, w_rpt;
    logic        w_push_v, w_pop, w_full, w_wr;
    logic [7:0]  w_push_d;

    assign w_evt    = r_armed && (ps2_key_i[10] != r_tog);
    assign w_s1_std = r_s1_v && !r_s1_ext;
    assign w_shift  = r_lsh | r_rsh;
    assign w_let    = f_letter(r_s1_scan);
    assign w_dig    = f_digit(r_s1_scan, w_shift);
    // every mapped code is nonzero, so zero doubles as "unmapped"
    assign w_code   = r_s1_ext ? f_ext(r_s1_scan) :
                      (w_let != 8'h00) ? (r_ctrl ? (w_let & 8'h1F) : (w_shift ^ r_caps) ? (w_let ^ 8'h20) : w_let) :
                      (w_dig != 8'h00) ? w_dig : f_misc(r_s1_scan);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_armed   <= 1'b0;
            r_tog     <= 1'b0;
            r_s1_v    <= 1'b0;
            r_s1_ext  <= 1'b0;
            r_s1_mk   <= 1'b0;
            r_s1_scan <= 8'h00;
            r_lsh     <= 1'b0;
            r_rsh     <= 1'b0;
            r_ctrl    <= 1'b0;
            r_caps    <= 1'b0;
            r_s2_push <= 1'b0;
            r_s2_brk  <= 1'b0;
            r_s2_ext  <= 1'b0;
            r_s2_scan <= 8'h00;
            r_s2_code <= 8'h00;
        end else begin
            r_armed   <= 1'b1;
            r_tog     <= ps2_key_i[10];
            r_s1_v    <= w_evt;
            r_s1_ext  <= ps2_key_i[8];
            r_s1_mk   <= ps2_key_i[9];
            r_s1_scan <= ps2_key_i[7:0];
            r_lsh     <= (w_s1_std && r_s1_scan == 8'h12) ? r_s1_mk : r_lsh;
            r_rsh     <= (w_s1_std && r_s1_scan == 8'h59) ? r_s1_mk : r_rsh;
            r_ctrl    <= (r_s1_v && r_s1_scan == 8'h14) ? r_s1_mk : r_ctrl;
            r_caps    <= (w_s1_std && r_s1_mk && r_s1_scan == 8'h58) ? ~r_caps : r_caps;
            r_s2_push <= r_s1_v && r_s1_mk && (w_code != 8'h00);
            r_s2_brk  <= r_s1_v && !r_s1_mk;
            r_s2_ext  <= r_s1_ext;
            r_s2_scan <= r_s1_scan;
            r_s2_code <= w_code;
        end
    end

    assign w_dly_done  = (r_state == DELAY) && (r_cnt == REPEAT_DLY - 24'd1);
    assign w_rate_done = (r_state == REPEAT) && (r_cnt == REPEAT_RATE - 24'd1);
    assign w_brk_hit   = r_s2_brk && (r_state != IDLE) && ({r_s2_ext, r_s2_scan} == r_rkey);
    // a fresh decoded push or a matching release pre-empts any repeat due this cycle
    assign w_rpt       = !r_s2_push && !w_brk_hit && (w_dly_done || w_rate_done);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_cnt   <= 24'd0;
            r_rkey  <= 9'd0;
            r_rcode <= 8'h00;
        end else if (r_s2_push) begin
            r_state <= DELAY;
            r_cnt   <= 24'd0;
            r_rkey  <= {r_s2_ext, r_s2_scan};
            r_rcode <= r_s2_code;
        end else if (w_brk_hit) begin
            r_state <= IDLE;
            r_cnt   <= 24'd0;
        end else if (w_dly_done || w_rate_done) begin
            r_state <= REPEAT;
            r_cnt   <= 24'd0;
        end else begin
            r_cnt   <= (r_state == IDLE) ? 24'd0 : r_cnt + 24'd1;
        end
    end

    assign w_push_v = r_s2_push || w_rpt;
    assign w_push_d = r_s2_push ? r_s2_code : r_rcode;
    assign w_full   = (r_fcnt == FULL);
    assign w_pop    = rd_i && valid_o;
    assign w_wr     = w_push_v && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wp] <= w_push_d;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_wp   <= w_wr ? r_wp + 1'b1 : r_wp;
            r_rp   <= w_pop ? r_rp + 1'b1 : r_rp;
            r_fcnt <= r_fcnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_ovf  <= r_ovf || (w_push_v && !w_wr);
        end
    end

    assign valid_o    = (r_fcnt != '0);
    assign data_o     = valid_o ? r_mem[r_rp] : 8'h00;
    assign count_o    = r_fcnt;
    assign overflow_o = r_ovf;
endmodule

// File: tb/tb_adam_kbd_fifo.sv
// tb_adam_kbd_fifo: directed checks of decode, modifiers, repeat timing, FIFO limits and reset
module tb_adam_kbd_fifo;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] key;
    logic        rd;
    logic [7:0]  data;
    logic        valid;
    logic [2:0]  count;
    logic        overflow;
    int          n_chk = 0;
    int          n_pass = 0;
    int          log_n[$];
    logic [7:0]  log_d[$];
    int          rpt_n[6]  = '{2, 12, 16, 20, 24, 28};
    int          rst_n[3]  = '{2, 8, 18};
    logic [7:0]  rst_d[3]  = '{8'h20, 8'h61, 8'h61};
    logic [7:0]  wrap_d[4] = '{8'h62, 8'h63, 8'h64, 8'h66};

    adam_kbd_fifo #(.DEPTH(4), .REPEAT_DLY(24'd10), .REPEAT_RATE(24'd4)) u_dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .ps2_key_i  (key),
        .rd_i       (rd),
        .data_o     (data),
        .valid_o    (valid),
        .count_o    (count),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input logic [7:0] s, input logic e, input logic m);
        key = {~key[10], m, e, s};
    endtask

    task automatic key_ev(input logic [7:0] s, input logic e, input logic m);
        set_key(s, e, m);
        tick();
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        rd = 1'b0;
        key = {1'b1, 1'b1, 1'b0, 8'h1C};
        tick(3);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", data, 0);
        reset_n = 1'b1;
        tick(3);
        check("no_evt_on_arm", valid, 0);

        key_ev(8'h1C, 0, 1);
        check("lat_k", valid, 0);
        tick();
        check("lat_k1", valid, 0);
        tick();
        check("lat_k2", valid, 1);
        check("a_data", data, 8'h61);
        check("a_count", count, 1);
        key_ev(8'h1C, 0, 0);
        pop();
        check("pop_valid", valid, 0);
        check("pop_count", count, 0);
        tick(3);

        key_ev(8'h12, 0, 1);
        key_ev(8'h1C, 0, 1);
        key_ev(8'h1C, 0, 0);
        key_ev(8'h12, 0, 0);
        key_ev(8'h1C, 0, 1);
        tick(2);
        check("shift_count", count, 2);
        check("shift_A", data, 8'h41);
        pop();
        check("unshift_a", data, 8'h61);
        check("unshift_cnt", count, 1);
        pop();
        key_ev(8'h1C, 0, 0);
        tick(3);
        check("no_brk_push", count, 0);

        key_ev(8'h59, 0, 1);
        key_ev(8'h1E, 0, 1);
        key_ev(8'h1E, 0, 0);
        key_ev(8'h59, 0, 0);
        key_ev(8'h45, 0, 1);
        key_ev(8'h45, 0, 0);
        tick(2);
        check("dig_count", count, 2);
        check("dig_at", data, 8'h40);
        pop();
        check("dig_0", data, 8'h30);
        pop();

        key_ev(8'h58, 0, 1);
        key_ev(8'h58, 0, 0);
        key_ev(8'h14, 0, 1);
        key_ev(8'h32, 0, 1);
        tick(2);
        check("ctrl_count", count, 1);
        check("ctrl_b", data, 8'h02);
        key_ev(8'h32, 0, 0);
        key_ev(8'h14, 0, 0);
        pop();
        key_ev(8'h75, 1, 1);
        tick(2);
        check("ext_count", count, 1);
        check("ext_up", data, 8'hA0);
        key_ev(8'h75, 1, 0);
        pop();
        key_ev(8'h1C, 0, 1);
        tick(2);
        check("caps_A", data, 8'h41);
        key_ev(8'h1C, 0, 0);
        pop();
        key_ev(8'h58, 0, 1);
        key_ev(8'h58, 0, 0);
        tick(3);
        check("t3_empty", count, 0);

        key_ev(8'h1C, 0, 1);
        key_ev(8'h1C, 0, 0);
        key_ev(8'h32, 0, 1);
        key_ev(8'h32, 0, 0);
        key_ev(8'h21, 0, 1);
        key_ev(8'h21, 0, 0);
        key_ev(8'h23, 0, 1);
        key_ev(8'h23, 0, 0);
        key_ev(8'h24, 0, 1);
        key_ev(8'h24, 0, 0);
        tick(3);
        check("full_count", count, 4);
        check("full_ovf", overflow, 1);
        check("full_head", data, 8'h61);
        key_ev(8'h2B, 0, 1);
        tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("pp_full_cnt", count, 4);
        check("pp_ovf_stuck", overflow, 1);
        key_ev(8'h2B, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("wrap_data", data, wrap_d[i]);
            pop();
        end
        check("wrap_empty", valid, 0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("rd_empty", count, 0);
        key_ev(8'h1C, 0, 1);
        tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("pp_empty_cnt", count, 1);
        check("pp_empty_d", data, 8'h61);
        key_ev(8'h1C, 0, 0);
        pop();
        tick(3);

        rd = 1'b1;
        key_ev(8'h29, 0, 1);
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (valid) begin
                log_n.push_back(n);
                log_d.push_back(data);
            end
            if (n == 28) set_key(8'h29, 0, 0);
        end
        check("rpt_pushes", log_n.size(), 6);
        for (int i = 0; i < 6 && i < log_n.size(); i++) begin
            check("rpt_time", log_n[i], rpt_n[i]);
            check("rpt_data", log_d[i], 8'h20);
        end

        log_n.delete();
        log_d.delete();
        key_ev(8'h29, 0, 1);
        for (int n = 1; n <= 35; n++) begin
            tick();
            if (valid) begin
                log_n.push_back(n);
                log_d.push_back(data);
            end
            if (n == 5) set_key(8'h1C, 0, 1);
            if (n == 18) set_key(8'h1C, 0, 0);
        end
        check("restart_pushes", log_n.size(), 3);
        for (int i = 0; i < 3 && i < log_n.size(); i++) begin
            check("restart_time", log_n[i], rst_n[i]);
            check("restart_data", log_d[i], rst_d[i]);
        end
        key_ev(8'h29, 0, 0);
        rd = 1'b0;
        tick(3);

        key_ev(8'h29, 0, 1);
        tick(16);
        check("pre_rst_cnt", count, 3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_cnt", count, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_ovf", overflow, 0);
        tick(20);
        check("post_rst_quiet", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
